paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/vga_pkg.sv | 26 ++
 rtl/paddle_ctrl_if.sv | 15 +
 rtl/btn_sync.sv | 28 ++
 rtl/paddle_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and paddle FSM types.
//   H_DISPLAY / V_DISPLAY : visible resolution
//   paddle_state_t        : paddle motion FSM states
//   COLOR_*               : common 3-bit colours
//   sat_inc4              : 4-bit saturating increment used for hold counting
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
    FAST_UP,
    FAST_DOWN
  } paddle_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Pixel-timing bundle driven by vga_sync and consumed by the paddle logic.
//   video_on : visible-region flag
//   p_tick   : pixel-enable pulse
//   pixel_x  : current column
//   pixel_y  : current line
// master = timing generator, slave = consumer.
interface paddle_ctrl_if;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;

  modport master (output video_on, p_tick, pixel_x, pixel_y);
  modport slave  (input  video_on, p_tick, pixel_x, pixel_y);
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw button input.
//   clk      : system clock
//   rst      : asynchronous active-low reset, clears both flops
//   async_in : raw asynchronous input
//   sync_out : synchronized copy, two clocks behind async_in
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/paddle_ctrl.sv
// Single-player paddle: button-driven vertical position with a slow/fast
// speed FSM evaluated once per frame, plus the paddle pixel renderer.
//   clk        : system clock (shared with vga_sync)
//   rst        : asynchronous active-low reset
//   but_up     : raw up button, active-high
//   but_down   : raw down button, active-high
//   sw         : paddle colour
//   vga        : pixel timing (video_on, p_tick, pixel_x, pixel_y)
//   rgb        : registered pixel colour, one clk behind the pixel inputs
//   paddle_y   : paddle top line
//   frame_tick : one-clk pulse per frame, at the start of vertical blank
module paddle_ctrl
  import vga_pkg::*;
#(
  parameter int         PADDLE_X_L  = 600,
  parameter int         PADDLE_X_R  = 603,
  parameter int         PADDLE_H    = 72,
  parameter int         STEP        = 4,
  parameter int         HOLD_FRAMES = 8,
  parameter logic [2:0] BG_COLOR    = 3'b000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         but_up,
  input  logic         but_down,
  input  logic [2:0]   sw,
  paddle_ctrl_if.slave vga,
  output logic [2:0]   rgb,
  output logic [9:0]   paddle_y,
  output logic         frame_tick
);

  localparam logic [9:0]  X_L        = 10'(PADDLE_X_L);
  localparam logic [9:0]  X_R        = 10'(PADDLE_X_R);
  localparam logic [9:0]  TICK_LINE  = 10'(V_DISPLAY);
  localparam logic [10:0] LINES11    = 11'(V_DISPLAY);
  localparam logic [10:0] H11        = 11'(PADDLE_H);
  localparam logic [10:0] STEP_SLOW  = 11'(STEP);
  localparam logic [10:0] STEP_FAST  = 11'(2 * STEP);
  localparam logic [9:0]  Y_MAX      = 10'(V_DISPLAY - PADDLE_H);
  localparam logic [9:0]  Y_HOME     = 10'((V_DISPLAY - PADDLE_H) / 2);
  localparam logic [3:0]  HOLD_LIMIT = 4'(HOLD_FRAMES);

  // Button synchronizers: bit 0 = up, bit 1 = down.
  logic [1:0] btn_raw;
  logic [1:0] btn_sync_w;
  assign btn_raw = {but_down, but_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      btn_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_raw[gi]),
        .sync_out (btn_sync_w[gi])
      );
    end
  endgenerate

  logic only_up;
  logic only_dn;
  assign only_up = btn_sync_w[0] & ~btn_sync_w[1];
  assign only_dn = btn_sync_w[1] & ~btn_sync_w[0];

  paddle_state_t state_reg, state_next;
  logic [3:0]    hold_cnt_reg, hold_next;
  logic [9:0]    paddle_y_reg, paddle_y_next;
  logic          frame_tick_reg;
  logic [2:0]    rgb_reg, rgb_next;

  logic [10:0]   step;
  logic [10:0]   y11;
  logic [10:0]   y_up;
  logic [10:0]   y_dn;

  // Next state and hold count, as they would be taken on a frame_tick.
  always_comb begin
    state_next = IDLE;
    hold_next  = 4'd0;
    if (only_up) begin
      if (state_reg == UP || state_reg == FAST_UP) begin
        hold_next  = sat_inc4(hold_cnt_reg);
        state_next = (state_reg == FAST_UP || hold_next >= HOLD_LIMIT) ? FAST_UP : UP;
      end else begin
        hold_next  = 4'd1;
        state_next = UP;
      end
    end else if (only_dn) begin
      if (state_reg == DOWN || state_reg == FAST_DOWN) begin
        hold_next  = sat_inc4(hold_cnt_reg);
        state_next = (state_reg == FAST_DOWN || hold_next >= HOLD_LIMIT) ? FAST_DOWN : DOWN;
      end else begin
        hold_next  = 4'd1;
        state_next = DOWN;
      end
    end
  end

  // Movement uses the speed of the state being entered; 11-bit math keeps
  // the underflow/overflow tests honest before clamping.
  always_comb begin
    case (state_next)
      UP, DOWN:           step = STEP_SLOW;
      FAST_UP, FAST_DOWN: step = STEP_FAST;
      default:            step = 11'd0;
    endcase
    y11           = {1'b0, paddle_y_reg};
    y_up          = y11 - step;
    y_dn          = y11 + step;
    paddle_y_next = paddle_y_reg;
    if (state_next == UP || state_next == FAST_UP) begin
      paddle_y_next = (y11 < step) ? 10'd0 : y_up[9:0];
    end else if (state_next == DOWN || state_next == FAST_DOWN) begin
      paddle_y_next = (y11 + H11 + step > LINES11) ? Y_MAX : y_dn[9:0];
    end
  end

  // Motion FSM: advances only on frame_tick, i.e. inside vertical blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 4'd0;
      paddle_y_reg <= Y_HOME;
    end else if (frame_tick_reg) begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_next;
      paddle_y_reg <= paddle_y_next;
    end
  end

  // Paddle rectangle test against the current (pre-update) position.
  always_comb begin
    rgb_next = BG_COLOR;
    if (!vga.video_on) begin
      rgb_next = COLOR_BLACK;
    end else if (vga.pixel_x >= X_L && vga.pixel_x <= X_R &&
                 {1'b0, vga.pixel_y} >= {1'b0, paddle_y_reg} &&
                 {1'b0, vga.pixel_y} <  {1'b0, paddle_y_reg} + H11) begin
      rgb_next = sw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick_reg <= 1'b0;
      rgb_reg        <= COLOR_BLACK;
    end else begin
      frame_tick_reg <= vga.p_tick && (vga.pixel_x == 10'd0) && (vga.pixel_y == TICK_LINE);
      rgb_reg        <= rgb_next;
    end
  end

  assign rgb        = rgb_reg;
  assign paddle_y   = paddle_y_reg;
  assign frame_tick = frame_tick_reg;

endmodule
